// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, with the carry
// rippling through stage registers. Valid/ready handshake with a global stall.

module adder_pipe_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
endmodule

module adder_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             stall;
  logic             adv;
  logic             last_vld;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub ? ~ci : ci;
  end

  assign stall    = last_vld && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall && !rst;

  // Stage g owns bits [LO +: CHUNK]. w_q carries the finished low sums in place of the
  // consumed a bits, so its upper part is the still-pending a skew. The b skew shrinks
  // by one chunk per stage and disappears after the last one.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int LO = g * CHUNK;
    localparam int BW = WIDTH - LO;

    logic             vld_i;
    logic             c_i;
    logic [WIDTH-1:0] w_i;
    logic [BW-1:0]    b_i;
    logic [CHUNK-1:0] sum;
    logic             cy;

    logic             vld_q, vld_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] w_q, w_d;

    if (g == 0) begin : g_in
      assign vld_i = in_valid && in_ready;
      assign w_i   = a;
      assign b_i   = b_eff;
      assign c_i   = c_eff;
    end else begin : g_in
      assign vld_i = g_stage[g-1].vld_q;
      assign w_i   = g_stage[g-1].w_q;
      assign b_i   = g_stage[g-1].g_skew.b_q;
      assign c_i   = g_stage[g-1].c_q;
    end

    adder_pipe_chunk #(.N(CHUNK)) u_chunk (
      .a  (w_i[LO +: CHUNK]),
      .b  (b_i[CHUNK-1:0]),
      .ci (c_i),
      .s  (sum),
      .co (cy)
    );

    always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      w_d   = w_q;
      if (adv) begin
        vld_d            = vld_i;
        c_d              = cy;
        w_d              = w_i;
        w_d[LO +: CHUNK] = sum;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        w_q   <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        w_q   <= w_d;
      end
    end

    if (g < STAGES - 1) begin : g_skew
      logic [BW-CHUNK-1:0] b_q, b_d;

      always_comb begin
        b_d = adv ? b_i[BW-1:CHUNK] : b_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) b_q <= '0;
        else     b_q <= b_d;
      end
    end else begin : g_last
      logic ovf_q, ovf_d;

      // The MSB chunk is added here, so both operand signs and the result sign meet.
      always_comb begin
        ovf_d = ovf_q;
        if (adv) ovf_d = (w_i[WIDTH-1] == b_i[BW-1]) && (sum[CHUNK-1] != w_i[WIDTH-1]);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end
    end
  end

  assign last_vld  = g_stage[STAGES-1].vld_q;
  assign out_valid = last_vld;
  assign r         = g_stage[STAGES-1].w_q;
  assign co        = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
endmodule
